// File: rtl/bin2bcd4_seq.sv
// Sequential binary-to-BCD converter (shift-add-3) producing four display digits A..D.
// Optional leading-zero blanking is enabled by defining LEAD_ZERO_BLANK_EN.
module bin2bcd4_seq #(
    parameter int IN_WIDTH = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] bin,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [3:0]          A,
    output logic [3:0]          B,
    output logic [3:0]          C,
    output logic [3:0]          D,
    output logic [3:0]          blank
);

    localparam int CW = $clog2(IN_WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t              state_reg, state_next;
    logic [IN_WIDTH-1:0] shift_reg;
    logic [15:0]         scratch_reg;
    logic [15:0]         scratch_adj;
    logic [CW-1:0]       cnt_reg;
    logic                ovf_reg;
    logic                ovf_in;
    logic [15:0]         digits_next;
    logic [3:0]          blank_next;
    logic [3:0]          blank_rst;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_add3
            assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                          ? scratch_reg[gi*4 +: 4] + 4'd3
                                          : scratch_reg[gi*4 +: 4];
        end

        // Narrower inputs can never exceed 9999, so the flag is tied off.
        if (IN_WIDTH >= 14) begin : g_ovf
            assign ovf_in = (bin > IN_WIDTH'(9999));
        end else begin : g_no_ovf
            assign ovf_in = 1'b0;
        end
    endgenerate

    assign digits_next = ovf_reg ? 16'h9999 : scratch_reg;

`ifdef LEAD_ZERO_BLANK_EN
    logic a_zero, b_zero, c_zero;
    assign a_zero     = (digits_next[15:12] == 4'd0);
    assign b_zero     = (digits_next[11:8]  == 4'd0);
    assign c_zero     = (digits_next[7:4]   == 4'd0);
    // Units digit always lit so a zero value still shows a single "0".
    assign blank_next = {a_zero, a_zero & b_zero, a_zero & b_zero & c_zero, 1'b0};
    assign blank_rst  = 4'b1110;
`else
    assign blank_next = 4'b0000;
    assign blank_rst  = 4'b0000;
`endif

    assign busy = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_reg == CW'(IN_WIDTH - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            A           <= 4'd0;
            B           <= 4'd0;
            C           <= 4'd0;
            D           <= 4'd0;
            blank       <= blank_rst;
        end else begin
            state_reg <= state_next;
            done      <= (state_reg == FINISH);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg   <= bin;
                        scratch_reg <= '0;
                        cnt_reg     <= '0;
                        ovf_reg     <= ovf_in;
                    end
                end
                SHIFT: begin
                    // Bits leaving the top of the scratch register are discarded.
                    {scratch_reg, shift_reg} <= {scratch_adj, shift_reg} << 1;
                    cnt_reg                  <= cnt_reg + CW'(1);
                end
                FINISH: begin
                    A        <= digits_next[15:12];
                    B        <= digits_next[11:8];
                    C        <= digits_next[7:4];
                    D        <= digits_next[3:0];
                    overflow <= ovf_reg;
                    blank    <= blank_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd4_seq.sv
// Directed self-checking bench for bin2bcd4_seq (IN_WIDTH = 14).
module tb_bin2bcd4_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic        busy, done, overflow;
    logic [3:0]  A, B, C, D, blank;

    int tests = 0;
    int fails = 0;

`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [3:0] BLANK_RST = LZB ? 4'b1110 : 4'b0000;

    bin2bcd4_seq #(.IN_WIDTH(14)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .overflow(overflow),
        .A(A), .B(B), .C(C), .D(D), .blank(blank)
    );

    always #5 clk = ~clk;

    // Caller is at a negedge; returns at the negedge where done is seen (or -1).
    task automatic convert(input logic [13:0] v, output int lat, output logic busy_seen);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        busy_seen = busy;
        lat       = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({busy, done, overflow} !== 3'b000 || {A, B, C, D} !== 16'h0000 || blank !== BLANK_RST) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b ovf=%b digits=%h blank=%b, required 0 0 0 0000 %b",
                     busy, done, overflow, {A, B, C, D}, blank, BLANK_RST);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        int lat;
        logic b;
        convert(14'd1234, lat, b);
        tests++;
        if (b !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy: busy=%b required 1", b);
        end
        tests++;
        if (lat != 15) begin
            fails++;
            $display("FAIL basic_latency: %0d edges required 15", lat);
        end
        tests++;
        if ({A, B, C, D} !== 16'h1234 || blank !== 4'b0000 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL basic_digits: digits=%h blank=%b ovf=%b required 1234 0000 0",
                     {A, B, C, D}, blank, overflow);
        end
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_pulse: done=%b busy=%b required 0 0", done, busy);
        end
        $display("[TB] bin=1234 -> %h blank=%b lat=%0d", {A, B, C, D}, blank, lat);
    endtask

    task automatic test_digits();
        logic [13:0] vin  [3] = '{14'd7, 14'd0, 14'd305};
        logic [15:0] vexp [3] = '{16'h0007, 16'h0000, 16'h0305};
        logic [3:0]  vblk [3] = '{4'b1110, 4'b1110, 4'b1000};
        int lat;
        logic b;
        for (int i = 0; i < 3; i++) begin
            convert(vin[i], lat, b);
            tests++;
            if (lat != 15 || {A, B, C, D} !== vexp[i] || blank !== (LZB ? vblk[i] : 4'b0000)
                || overflow !== 1'b0) begin
                fails++;
                $display("FAIL digits_%0d: lat=%0d digits=%h blank=%b ovf=%b required 15 %h %b 0",
                         vin[i], lat, {A, B, C, D}, blank, overflow, vexp[i],
                         LZB ? vblk[i] : 4'b0000);
            end
            $display("[TB] bin=%0d -> %h blank=%b", vin[i], {A, B, C, D}, blank);
        end
    endtask

    task automatic test_overflow();
        logic [13:0] vin  [3] = '{14'd10000, 14'd9999, 14'd16383};
        logic        vovf [3] = '{1'b1, 1'b0, 1'b1};
        int lat;
        logic b;
        for (int i = 0; i < 3; i++) begin
            convert(vin[i], lat, b);
            tests++;
            if (lat != 15 || overflow !== vovf[i] || {A, B, C, D} !== 16'h9999 || blank !== 4'b0000) begin
                fails++;
                $display("FAIL overflow_%0d: lat=%0d ovf=%b digits=%h blank=%b required 15 %b 9999 0000",
                         vin[i], lat, overflow, {A, B, C, D}, blank, vovf[i]);
            end
            $display("[TB] bin=%0d -> %h ovf=%b", vin[i], {A, B, C, D}, overflow);
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        bin   = 14'd42;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        bin   = 14'd77;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        tests++;
        if (dones != 1 || {A, B, C, D} !== 16'h0042 || blank !== (LZB ? 4'b1100 : 4'b0000)) begin
            fails++;
            $display("FAIL ignore_start: dones=%0d digits=%h blank=%b required 1 0042 %b",
                     dones, {A, B, C, D}, blank, LZB ? 4'b1100 : 4'b0000);
        end
        $display("[TB] start while busy -> dones=%0d digits=%h", dones, {A, B, C, D});
    endtask

    task automatic test_mid_reset();
        int dones = 0;
        bin   = 14'd555;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({busy, done, overflow} !== 3'b000 || {A, B, C, D} !== 16'h0000 || blank !== BLANK_RST) begin
            fails++;
            $display("FAIL mid_reset: busy=%b done=%b ovf=%b digits=%h blank=%b required 0 0 0 0000 %b",
                     busy, done, overflow, {A, B, C, D}, blank, BLANK_RST);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL mid_reset_no_done: dones=%0d required 0", dones);
        end
        $display("[TB] reset mid-conversion -> busy=%b dones=%0d", busy, dones);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic b;
        convert(14'd12, lat, b);
        tests++;
        if (lat != 15 || {A, B, C, D} !== 16'h0012 || blank !== (LZB ? 4'b1100 : 4'b0000)) begin
            fails++;
            $display("FAIL b2b_first: lat=%0d digits=%h blank=%b required 15 0012 %b",
                     lat, {A, B, C, D}, blank, LZB ? 4'b1100 : 4'b0000);
        end
        convert(14'd3456, lat, b);
        tests++;
        if (b !== 1'b1 || lat != 15 || {A, B, C, D} !== 16'h3456 || blank !== 4'b0000) begin
            fails++;
            $display("FAIL b2b_second: busy=%b lat=%0d digits=%h blank=%b required 1 15 3456 0000",
                     b, lat, {A, B, C, D}, blank);
        end
        $display("[TB] back-to-back -> %h lat=%0d", {A, B, C, D}, lat);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        test_reset();
        test_basic();
        test_digits();
        test_overflow();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
